// File: rtl/image_pkg.sv
// rtl/image_pkg.sv - frame geometry, header bytes and tx state type for image_stream_tx
// IMAGE_TX_HEADER_EN adds the HEADER state to the enum.
package image_pkg;
    localparam int IMG_ROWS      = 150;
    localparam int IMG_COLS      = 300;
    localparam int BYTES_PER_ROW = 38;

    localparam logic [7:0] HDR_BYTE0 = 8'hA5;
    localparam logic [7:0] HDR_BYTE1 = 8'h5A;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_ROW,
        SEND,
        DONE
`ifdef IMAGE_TX_HEADER_EN
        , HEADER
`endif
    } tx_state_t;
endpackage

// File: rtl/row_byte_select.sv
// rtl/row_byte_select.sv - picks byte col of a buffered row, MSB = leftmost pixel, zero padded
module row_byte_select
    import image_pkg::*;
(
    input  logic [0:IMG_COLS-1] row_buf,
    input  logic [5:0]          col,
    output logic [7:0]          data
);
    // One spare byte of padding keeps the look-ahead select (col+1 at col 37) in range.
    logic [0:8*(BYTES_PER_ROW+1)-1] padded;

    always_comb begin
        padded             = '0;
        padded[0:IMG_COLS-1] = row_buf;
        data               = padded[{col, 3'b000} +: 8];
    end
endmodule

// File: rtl/image_stream_tx.sv
// rtl/image_stream_tx.sv - streams a 150x300 binary frame as packed bytes with valid/ready
// Define IMAGE_TX_HEADER_EN to prefix each frame with header bytes 0xA5, 0x5A.
module image_stream_tx
    import image_pkg::*;
(
    input  logic                               pixclk,
    input  logic                               RESET,
    input  logic                               dataready,
    input  logic [0:IMG_ROWS-1][0:IMG_COLS-1]  image,
    output logic                               cansend,
    output logic [7:0]                         tx_data,
    output logic                               tx_valid,
    input  logic                               tx_ready,
    output logic                               tx_sof,
    output logic                               tx_eol,
    output logic                               frame_done
);
    localparam logic [5:0] LAST_COL = 6'(BYTES_PER_ROW - 1);
    localparam logic [7:0] LAST_ROW = 8'(IMG_ROWS - 1);

    tx_state_t           state;
    logic [7:0]          row;
    logic [5:0]          col;
    logic [0:IMG_COLS-1] row_buf;
    logic [0:IMG_COLS-1] sel_row;
    logic [5:0]          sel_col;
    logic [7:0]          sel_byte;
    logic                xfer;
`ifdef IMAGE_TX_HEADER_EN
    logic                hdr_idx;
`endif

    assign xfer = tx_valid & tx_ready;

    // The selector looks one byte ahead so tx_data can be registered on each transfer;
    // during LOAD_ROW it reads the incoming row directly to prime byte 0.
    always_comb begin
        sel_row = row_buf;
        sel_col = col + 6'd1;
        if (state == LOAD_ROW) begin
            sel_row = image[row];
            sel_col = '0;
        end
    end

    row_byte_select u_sel (
        .row_buf (sel_row),
        .col     (sel_col),
        .data    (sel_byte)
    );

    always_ff @(posedge pixclk) begin
        if (RESET) begin
            state      <= IDLE;
            row        <= '0;
            col        <= '0;
            row_buf    <= '0;
            tx_data    <= 8'h00;
            tx_valid   <= 1'b0;
            tx_sof     <= 1'b0;
            tx_eol     <= 1'b0;
            frame_done <= 1'b0;
            cansend    <= 1'b1;
`ifdef IMAGE_TX_HEADER_EN
            hdr_idx    <= 1'b0;
`endif
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: if (dataready) begin
                    cansend <= 1'b0;
                    row     <= '0;
                    col     <= '0;
`ifdef IMAGE_TX_HEADER_EN
                    state    <= HEADER;
                    tx_data  <= HDR_BYTE0;
                    tx_valid <= 1'b1;
                    tx_sof   <= 1'b1;
                    hdr_idx  <= 1'b0;
`else
                    state   <= LOAD_ROW;
`endif
                end
`ifdef IMAGE_TX_HEADER_EN
                HEADER: if (xfer) begin
                    if (!hdr_idx) begin
                        tx_data <= HDR_BYTE1;
                        tx_sof  <= 1'b0;
                        hdr_idx <= 1'b1;
                    end else begin
                        tx_valid <= 1'b0;
                        state    <= LOAD_ROW;
                    end
                end
`endif
                LOAD_ROW: begin
                    row_buf  <= image[row];
                    col      <= '0;
                    tx_data  <= sel_byte;
                    tx_valid <= 1'b1;
`ifdef IMAGE_TX_HEADER_EN
                    tx_sof   <= 1'b0;
`else
                    tx_sof   <= (row == '0);
`endif
                    tx_eol   <= 1'b0;
                    state    <= SEND;
                end
                SEND: if (xfer) begin
                    tx_sof <= 1'b0;
                    if (col != LAST_COL) begin
                        col     <= col + 6'd1;
                        tx_data <= sel_byte;
                        tx_eol  <= (sel_col == LAST_COL);
                    end else begin
                        tx_valid <= 1'b0;
                        tx_eol   <= 1'b0;
                        if (row == LAST_ROW) begin
                            frame_done <= 1'b1;
                            state      <= DONE;
                        end else begin
                            row   <= row + 8'd1;
                            state <= LOAD_ROW;
                        end
                    end
                end
                DONE: begin
                    row     <= '0;
                    col     <= '0;
                    cansend <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_image_stream_tx.sv
// tb/tb_image_stream_tx.sv - table-driven, scoreboarded bench for image_stream_tx
module tb_image_stream_tx;
`ifdef IMAGE_TX_HEADER_EN
    localparam int HDR = 2;
`else
    localparam int HDR = 0;
`endif
    localparam int NB = 5700 + HDR;

    logic              pixclk = 1'b0;
    logic              RESET = 1'b1;
    logic              dataready = 1'b0;
    logic              tx_ready = 1'b0;
    logic [0:149][0:299] image;
    logic              cansend, tx_valid, tx_sof, tx_eol, frame_done;
    logic [7:0]        tx_data;

    always #5 pixclk = ~pixclk;

    image_stream_tx dut (
        .pixclk     (pixclk),
        .RESET      (RESET),
        .dataready  (dataready),
        .image      (image),
        .cansend    (cansend),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_sof     (tx_sof),
        .tx_eol     (tx_eol),
        .frame_done (frame_done)
    );

    typedef struct { logic [7:0] data; logic sof; logic eol; } exp_t;
    typedef struct { int pat; int stall_at; int dr_at; int rst_at; int exp_bytes; int exp_eol; int exp_done; } vec_t;

    exp_t       exp_q[$];
    vec_t       vecs[6];
    logic [7:0] log_b[0:NB];
    int         total = 0;
    int         bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    function automatic logic [7:0] model_byte(input int r, input int k);
        logic [7:0] b = 8'h00;
        for (int i = 0; i < 8; i++)
            if (8 * k + i < 300) b[7 - i] = image[r][8 * k + i];
        return b;
    endfunction

    task automatic fill_image(input int pat);
        for (int r = 0; r < 150; r++)
            for (int c = 0; c < 300; c++)
                case (pat)
                    0:       image[r][c] = 1'b1;
                    1:       image[r][c] = 1'((r + c) & 1);
                    default: image[r][c] = 1'($urandom_range(0, 1));
                endcase
    endtask

    task automatic push_frame();
        exp_t e;
        exp_q.delete();
`ifdef IMAGE_TX_HEADER_EN
        e.data = 8'hA5; e.sof = 1'b1; e.eol = 1'b0; exp_q.push_back(e);
        e.data = 8'h5A; e.sof = 1'b0; e.eol = 1'b0; exp_q.push_back(e);
`endif
        for (int r = 0; r < 150; r++)
            for (int k = 0; k < 38; k++) begin
                e.data = model_byte(r, k);
                e.sof  = (HDR == 0 && r == 0 && k == 0);
                e.eol  = (k == 37);
                exp_q.push_back(e);
            end
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        int sent = 0, eols = 0, dones = 0, cyc = 0, stall_left = 0;
        bit prev_done = 0, rst_pend = 0, finished = 0;
        fill_image(v.pat);
        push_frame();
        while (cyc < 10 && cansend !== 1'b1) begin
            @(negedge pixclk);
            cyc++;
        end
        check("cansend_idle", cansend, 1);
        tx_ready  = 1'b1;
        dataready = 1'b1;
        cyc = 0;
        while (cyc < 8000 && !finished) begin
            @(negedge pixclk);
            cyc++;
            dataready = 1'b0;
            if (rst_pend) begin
                check("rst_valid", tx_valid, 0);
                check("rst_cansend", cansend, 1);
                check("rst_no_done", frame_done, 0);
                RESET    = 1'b0;
                finished = 1;
            end else if (prev_done) begin
                check("cansend_after_done", cansend, 1);
                finished = 1;
            end else begin
                if (frame_done) begin
                    dones++;
                    prev_done = 1;
                end
                tx_ready = (stall_left == 0);
                if (stall_left > 0) begin
                    stall_left--;
                    check("stall_valid", tx_valid, 1);
                    if (exp_q.size() > 0) check("stall_data", tx_data, exp_q[0].data);
                end
                if (v.rst_at >= 0 && sent == v.rst_at) begin
                    RESET    = 1'b1;
                    tx_ready = 1'b0;
                    rst_pend = 1;
                end else if (tx_valid && tx_ready) begin
                    if (exp_q.size() == 0) begin
                        check("extra_byte", sent + 1, v.exp_bytes);
                    end else begin
                        e = exp_q.pop_front();
                        check($sformatf("data[%0d]", sent), tx_data, e.data);
                        check($sformatf("sof[%0d]", sent), tx_sof, e.sof);
                        check($sformatf("eol[%0d]", sent), tx_eol, e.eol);
                    end
                    log_b[sent] = tx_data;
                    if (tx_eol) eols++;
                    sent++;
                    if (sent == v.stall_at) stall_left = 20;
                    if (sent == v.dr_at) begin
                        dataready = 1'b1;
                        check("cansend_busy", cansend, 0);
                    end
                end
            end
        end
        tx_ready = 1'b0;
        check("finished", finished, 1);
        check("byte_count", sent, v.exp_bytes);
        check("eol_count", eols, v.exp_eol);
        check("done_count", dones, v.exp_done);
    endtask

    initial begin
        vecs[0] = '{0, -1, -1, -1, NB, 150, 1};
        vecs[1] = '{1, -1, -1, -1, NB, 150, 1};
        vecs[2] = '{0, HDR + 5 * 38 + 10, -1, -1, NB, 150, 1};
        vecs[3] = '{2, -1, HDR + 10 * 38 + 3, -1, NB, 150, 1};
        vecs[4] = '{0, -1, -1, HDR + 70 * 38 + 5, HDR + 70 * 38 + 5, 70, 0};
        vecs[5] = '{1, -1, -1, -1, NB, 150, 1};

        repeat (3) @(negedge pixclk);
        RESET = 1'b0;
        check("reset_valid", tx_valid, 0);
        check("reset_data", tx_data, 0);
        check("reset_sof", tx_sof, 0);
        check("reset_eol", tx_eol, 0);
        check("reset_done", frame_done, 0);
        check("reset_cansend", cansend, 1);

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i]);
            if (i == 0) begin
                check("ones_byte0", log_b[HDR], 8'hFF);
                check("ones_byte37", log_b[HDR + 37], 8'hF0);
`ifdef IMAGE_TX_HEADER_EN
                check("hdr_byte0", log_b[0], 8'hA5);
                check("hdr_byte1", log_b[1], 8'h5A);
`endif
            end
            if (i == 1 || i == 5) begin
                check("chk_r0_b0", log_b[HDR], 8'h55);
                check("chk_r1_b0", log_b[HDR + 38], 8'hAA);
                check("chk_r0_b37", log_b[HDR + 37], 8'h50);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
